// File: rtl/eerrl_pkg.sv
// Shared constants for the EERRL routing blocks: table geometry, packet types,
// and the state encoding of the next-hop selector.
package eerrl_pkg;
    localparam int WORD_WIDTH = 16;
    localparam int MEM_DEPTH  = 2048;

    localparam logic [7:0] PKT_HELLO = 8'h01;
    localparam logic [7:0] PKT_DATA  = 8'h02;
    localparam logic [7:0] PKT_ACK   = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } qmax_state_t;
endpackage

// File: rtl/hop_better_cmp.sv
// Decides whether a candidate neighbour beats the current best: higher Q wins,
// equal Q falls back to higher residual energy; full ties keep the incumbent.
module hop_better_cmp #(
    parameter int WORD_WIDTH = eerrl_pkg::WORD_WIDTH
) (
    input  logic [WORD_WIDTH-1:0] cand_q,
    input  logic [WORD_WIDTH-1:0] cand_energy,
    input  logic [WORD_WIDTH-1:0] best_q,
    input  logic [WORD_WIDTH-1:0] best_energy,
    input  logic                  found,
    output logic                  replace
);
    assign replace = !found
                  || (cand_q > best_q)
                  || ((cand_q == best_q) && (cand_energy > best_energy));
endmodule

// File: rtl/qmax_hop_select.sv
// Scans the neighbour table after a Q-update and picks the eligible entry with
// the highest Q-value; drives the bank read index and reports a done pulse.
module qmax_hop_select #(
    parameter int WORD_WIDTH    = eerrl_pkg::WORD_WIDTH,
    parameter int MAX_NEIGHBORS = eerrl_pkg::MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] neighborCount,
    input  logic [WORD_WIDTH-1:0] myClusterID,
    input  logic                  filterCluster,
    input  logic [WORD_WIDTH-1:0] minEnergy,
    output logic [WORD_WIDTH-1:0] rdIndex,
    input  logic [WORD_WIDTH-1:0] mSourceID,
    input  logic [WORD_WIDTH-1:0] mClusterID,
    input  logic [WORD_WIDTH-1:0] mEnergyLeft,
    input  logic [WORD_WIDTH-1:0] mQValue,
    output logic [WORD_WIDTH-1:0] bestID,
    output logic [WORD_WIDTH-1:0] bestClusterID,
    output logic [WORD_WIDTH-1:0] bestEnergy,
    output logic [WORD_WIDTH-1:0] bestQValue,
    output logic                  found,
    output logic                  busy,
    output logic                  done
);
    import eerrl_pkg::*;

    typedef logic [WORD_WIDTH-1:0] word_t;
    localparam word_t MAX_N = word_t'(MAX_NEIGHBORS);

    qmax_state_t state, state_nxt;
    word_t       n_lat, cluster_lat, min_e_lat;
    logic        filt_lat;
    logic        pending;   // bank data holds entry rdIndex-1
    logic        tail;      // index held at N-1; bank data holds the last entry
    logic        start, last_idx, cmp_vld, eligible, replace;

    assign start    = (state == ST_IDLE) && en;
    assign last_idx = (rdIndex == n_lat - word_t'(1));
    assign cmp_vld  = (state == ST_SCAN) && (pending || tail);
    assign eligible = (mEnergyLeft >= min_e_lat)
                   && (!filt_lat || (mClusterID == cluster_lat) || (mSourceID == cluster_lat));

    assign busy = (state == ST_SCAN);
    assign done = (state == ST_DONE);

    hop_better_cmp #(.WORD_WIDTH(WORD_WIDTH)) u_cmp (
        .cand_q      (mQValue),
        .cand_energy (mEnergyLeft),
        .best_q      (bestQValue),
        .best_energy (bestEnergy),
        .found       (found),
        .replace     (replace)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en) state_nxt = (neighborCount == '0) ? ST_DONE : ST_SCAN;
            ST_SCAN: if (tail) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            n_lat         <= '0;
            cluster_lat   <= '0;
            min_e_lat     <= '0;
            filt_lat      <= 1'b0;
            pending       <= 1'b0;
            tail          <= 1'b0;
            rdIndex       <= '0;
            found         <= 1'b0;
            bestID        <= '0;
            bestClusterID <= '0;
            bestEnergy    <= '0;
            bestQValue    <= '0;
        end else if (start) begin
            n_lat         <= (neighborCount > MAX_N) ? MAX_N : neighborCount;
            cluster_lat   <= myClusterID;
            min_e_lat     <= minEnergy;
            filt_lat      <= filterCluster;
            pending       <= 1'b0;
            tail          <= 1'b0;
            rdIndex       <= '0;
            found         <= 1'b0;
            bestID        <= '0;
            bestClusterID <= '0;
            bestEnergy    <= '0;
            bestQValue    <= '0;
        end else if (state == ST_SCAN) begin
            if (cmp_vld && eligible && replace) begin
                found         <= 1'b1;
                bestID        <= mSourceID;
                bestClusterID <= mClusterID;
                bestEnergy    <= mEnergyLeft;
                bestQValue    <= mQValue;
            end
            if (!tail) begin
                if (last_idx) begin
                    pending <= 1'b0;
                    tail    <= 1'b1;
                end else begin
                    rdIndex <= rdIndex + word_t'(1);
                    pending <= 1'b1;
                end
            end
        end else if (state == ST_DONE) begin
            // hand the banks back to the Q-update stage
            rdIndex <= '0;
            pending <= 1'b0;
            tail    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_qmax_hop_select.sv
// Directed bench for qmax_hop_select with a registered neighbour-bank model.
module tb_qmax_hop_select;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b0;
    logic [15:0] neighborCount = '0, myClusterID = '0, minEnergy = '0;
    logic        filterCluster = 1'b0;
    logic [15:0] rdIndex, mSourceID, mClusterID, mEnergyLeft, mQValue;
    logic [15:0] bestID, bestClusterID, bestEnergy, bestQValue;
    logic        found, busy, done;

    logic [15:0] id_mem [2048];
    logic [15:0] cl_mem [2048];
    logic [15:0] e_mem  [2048];
    logic [15:0] q_mem  [2048];

    int checks = 0;
    int failures = 0;

    qmax_hop_select dut (
        .clk(clk), .nrst(nrst), .en(en), .neighborCount(neighborCount),
        .myClusterID(myClusterID), .filterCluster(filterCluster), .minEnergy(minEnergy),
        .rdIndex(rdIndex), .mSourceID(mSourceID), .mClusterID(mClusterID),
        .mEnergyLeft(mEnergyLeft), .mQValue(mQValue),
        .bestID(bestID), .bestClusterID(bestClusterID), .bestEnergy(bestEnergy),
        .bestQValue(bestQValue), .found(found), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mSourceID   <= id_mem[rdIndex[10:0]];
        mClusterID  <= cl_mem[rdIndex[10:0]];
        mEnergyLeft <= e_mem[rdIndex[10:0]];
        mQValue     <= q_mem[rdIndex[10:0]];
    end

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) begin
            id_mem[i] = '0; cl_mem[i] = '0; e_mem[i] = '0; q_mem[i] = '0;
        end
    endtask

    task automatic load(input int k, input logic [15:0] id, input logic [15:0] cl,
                        input logic [15:0] e, input logic [15:0] q);
        id_mem[k] = id; cl_mem[k] = cl; e_mem[k] = e; q_mem[k] = q;
    endtask

    task automatic load_basic();
        clear_mem();
        load(0, 16'h000A, 16'h0001, 16'h8000, 16'h1000);
        load(1, 16'h000B, 16'h0001, 16'h4000, 16'h3000);
        load(2, 16'h000C, 16'h0001, 16'h8000, 16'h2000);
        load(3, 16'h000D, 16'h0001, 16'h4000, 16'h3000);
    endtask

    // Pulses en for one edge (E0); cyc = edges after E0 until done is seen.
    task automatic run_scan(input logic [15:0] cnt, output int cyc, output logic [15:0] max_rd);
        repeat (2) @(negedge clk);
        neighborCount = cnt;
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        cyc = 0;
        max_rd = rdIndex;
        while (!done && cyc < 5000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (rdIndex > max_rd) max_rd = rdIndex;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL scan_timeout: done never seen after %0d cycles, required within 5000", cyc);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rdIndex, bestID, bestClusterID, bestEnergy, bestQValue, found, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rd=%h id=%h cl=%h e=%h q=%h f=%b b=%b d=%b, required all 0",
                     rdIndex, bestID, bestClusterID, bestEnergy, bestQValue, found, busy, done);
        end
        nrst = 1'b1;
    endtask

    task automatic test_empty();
        int cyc; logic [15:0] mr;
        minEnergy = '0; filterCluster = 1'b0;
        run_scan(16'd0, cyc, mr);
        checks++;
        if (cyc !== 0) begin
            failures++;
            $display("FAIL empty_latency: done after %0d extra edges, required 0 (one cycle after en)", cyc);
        end
        checks++;
        if ({found, bestID, bestClusterID, bestEnergy, bestQValue} !== '0) begin
            failures++;
            $display("FAIL empty_result: found=%b id=%h q=%h, required all 0", found, bestID, bestQValue);
        end
    endtask

    task automatic test_basic_max();
        int cyc; logic [15:0] mr;
        load_basic();
        minEnergy = '0; filterCluster = 1'b0;
        repeat (2) @(negedge clk);
        neighborCount = 16'd4; en = 1'b1;
        @(posedge clk); @(negedge clk);
        en = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy: busy=%b after start edge, required 1", busy);
        end
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); cyc++; @(negedge clk);
        end
        checks++;
        if (cyc !== 5) begin
            failures++;
            $display("FAIL basic_latency: done after %0d cycles, required 5", cyc);
        end
        checks++;
        if ({found, bestID, bestClusterID, bestEnergy, bestQValue} !== {1'b1, 16'h000B, 16'h0001, 16'h4000, 16'h3000}) begin
            failures++;
            $display("FAIL basic_result: found=%b id=%h cl=%h e=%h q=%h, required 1 000b 0001 4000 3000",
                     found, bestID, bestClusterID, bestEnergy, bestQValue);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if ({done, busy, rdIndex, bestID} !== {1'b0, 1'b0, 16'h0000, 16'h000B}) begin
            failures++;
            $display("FAIL basic_hold: done=%b busy=%b rd=%h id=%h, required 0 0 0000 000b",
                     done, busy, rdIndex, bestID);
        end
    endtask

    task automatic test_energy_tiebreak();
        int cyc; logic [15:0] mr;
        clear_mem();
        load(0, 16'h0021, 16'h0001, 16'h1800, 16'h3000);
        load(1, 16'h0022, 16'h0001, 16'h8000, 16'h3000);
        load(2, 16'h0023, 16'h0001, 16'hF000, 16'h2000);
        minEnergy = '0; filterCluster = 1'b0;
        run_scan(16'd3, cyc, mr);
        checks++;
        if ({found, bestID, bestEnergy, bestQValue} !== {1'b1, 16'h0022, 16'h8000, 16'h3000}) begin
            failures++;
            $display("FAIL tiebreak_result: id=%h e=%h q=%h, required 0022 8000 3000", bestID, bestEnergy, bestQValue);
        end
    endtask

    task automatic test_energy_filter();
        int cyc; logic [15:0] mr;
        clear_mem();
        load(0, 16'h0031, 16'h0001, 16'h1000, 16'h5000);
        load(1, 16'h0032, 16'h0001, 16'h2000, 16'h4000);
        load(2, 16'h0033, 16'h0001, 16'h9000, 16'h1000);
        minEnergy = 16'h2000; filterCluster = 1'b0;
        run_scan(16'd3, cyc, mr);
        checks++;
        if ({found, bestID, bestEnergy, bestQValue} !== {1'b1, 16'h0032, 16'h2000, 16'h4000}) begin
            failures++;
            $display("FAIL energy_filter: id=%h e=%h q=%h, required 0032 2000 4000", bestID, bestEnergy, bestQValue);
        end
    endtask

    task automatic test_cluster_filter();
        int cyc; logic [15:0] mr;
        clear_mem();
        load(0, 16'h0005, 16'h0001, 16'h8000, 16'h7000);
        load(1, 16'h0002, 16'h0003, 16'h8000, 16'h3000);
        load(2, 16'h0006, 16'h0002, 16'h8000, 16'h4000);
        load(3, 16'h0007, 16'h0004, 16'h8000, 16'h6000);
        minEnergy = '0; filterCluster = 1'b1; myClusterID = 16'h0002;
        run_scan(16'd4, cyc, mr);
        checks++;
        if ({found, bestID, bestClusterID, bestQValue} !== {1'b1, 16'h0006, 16'h0002, 16'h4000}) begin
            failures++;
            $display("FAIL cluster_filter: id=%h cl=%h q=%h, required 0006 0002 4000", bestID, bestClusterID, bestQValue);
        end
        filterCluster = 1'b0;
    endtask

    task automatic test_all_fail();
        int cyc; logic [15:0] mr;
        load_basic();
        minEnergy = 16'hFFFF; filterCluster = 1'b0;
        run_scan(16'd4, cyc, mr);
        checks++;
        if ({found, bestID, bestClusterID, bestEnergy, bestQValue} !== '0) begin
            failures++;
            $display("FAIL all_fail: found=%b id=%h cl=%h e=%h q=%h, required all 0",
                     found, bestID, bestClusterID, bestEnergy, bestQValue);
        end
        minEnergy = '0;
    endtask

    task automatic test_en_ignored();
        int cyc;
        load_basic();
        minEnergy = '0; filterCluster = 1'b0;
        repeat (2) @(negedge clk);
        neighborCount = 16'd4; en = 1'b1;
        @(posedge clk); @(negedge clk);
        en = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            if (cyc == 1) begin en = 1'b1; neighborCount = 16'd1; end
            if (cyc == 3) en = 1'b0;
            @(posedge clk); cyc++; @(negedge clk);
        end
        en = 1'b0;
        checks++;
        if (cyc !== 5) begin
            failures++;
            $display("FAIL en_ignored_latency: done after %0d cycles, required 5", cyc);
        end
        checks++;
        if ({found, bestID, bestQValue} !== {1'b1, 16'h000B, 16'h3000}) begin
            failures++;
            $display("FAIL en_ignored_result: id=%h q=%h, required 000b 3000", bestID, bestQValue);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; logic [15:0] mr;
        load_basic();
        repeat (2) @(negedge clk);
        neighborCount = 16'd4; en = 1'b1;
        @(posedge clk); @(negedge clk);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({rdIndex, bestID, bestClusterID, bestEnergy, bestQValue, found, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_mid: rd=%h id=%h q=%h f=%b b=%b d=%b, required all 0",
                     rdIndex, bestID, bestQValue, found, busy, done);
        end
        @(negedge clk);
        nrst = 1'b1;
        run_scan(16'd4, cyc, mr);
        checks++;
        if ({cyc[7:0], found, bestID, bestQValue} !== {8'd5, 1'b1, 16'h000B, 16'h3000}) begin
            failures++;
            $display("FAIL reset_rescan: cyc=%0d id=%h q=%h, required 5 000b 3000", cyc, bestID, bestQValue);
        end
    endtask

    task automatic test_clamp();
        int cyc; logic [15:0] mr;
        clear_mem();
        load(0, 16'h0001, 16'h0001, 16'h0001, 16'h0010);
        load(2047, 16'h07FF, 16'h0001, 16'h0100, 16'hFFFF);
        minEnergy = '0; filterCluster = 1'b0;
        run_scan(16'd3000, cyc, mr);
        checks++;
        if (cyc !== 2049) begin
            failures++;
            $display("FAIL clamp_latency: done after %0d cycles, required 2049", cyc);
        end
        checks++;
        if (mr !== 16'd2047) begin
            failures++;
            $display("FAIL clamp_max_index: max rdIndex %0d, required 2047", mr);
        end
        checks++;
        if ({found, bestID, bestEnergy, bestQValue} !== {1'b1, 16'h07FF, 16'h0100, 16'hFFFF}) begin
            failures++;
            $display("FAIL clamp_result: id=%h e=%h q=%h, required 07ff 0100 ffff", bestID, bestEnergy, bestQValue);
        end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_empty();
        test_basic_max();
        test_energy_tiebreak();
        test_energy_filter();
        test_cluster_filter();
        test_all_fail();
        test_en_ignored();
        test_reset_mid();
        test_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/qmax_hop_select.md
# qmax_hop_select

Downstream consumer of the Q-table update stage: after the neighbour table (ID, cluster ID, energy, Q-value banks) has been written, this block scans the first `neighborCount` entries and selects the next hop with the highest Q-value. Entries are filtered by minimum residual energy and, optionally, by cluster membership. The block drives the shared read index of the neighbour banks and returns the winning entry's fields plus a one-cycle `done` pulse to the routing/TX controller.

## Interface
- `WORD_WIDTH`, 16: width of every table field and of the index.
- `MAX_NEIGHBORS`, 2048: table depth; a larger count is clamped to this value.

- `clk`  in  1: system clock, rising edge.
- `nrst`  in  1: reset, asynchronous, active-low.
- `en`  in  1: start pulse; sampled only in IDLE.
- `neighborCount`  in  WORD_WIDTH: number of valid table entries.
- `myClusterID`  in  WORD_WIDTH: own cluster ID, used when `filterCluster`=1.
- `filterCluster`  in  1: restrict candidates to the own cluster.
- `minEnergy`  in  WORD_WIDTH: entries with `mEnergyLeft` < `minEnergy` are skipped.
- `rdIndex`  out  WORD_WIDTH: read index to all neighbour banks.
- `mSourceID`, `mClusterID`, `mEnergyLeft`, `mQValue`  in  WORD_WIDTH each: bank read data, registered, 1-cycle latency.
- `bestID`, `bestClusterID`, `bestEnergy`, `bestQValue`  out  WORD_WIDTH each: winning entry.
- `found`  out  1: at least one entry passed the filters.
- `busy`  out  1: scan in progress.
- `done`  out  1: one-cycle pulse when the results are final.

## Operation
- States:
  - IDLE → SCAN on `en`=1 when `neighborCount`≠0.
  - IDLE → DONE on `en`=1 when `neighborCount`=0.
  - SCAN → DONE after the last entry is compared.
  - DONE → IDLE unconditionally.
- On start:
  - Latch `min(neighborCount, MAX_NEIGHBORS)` as N, together with `myClusterID`, `filterCluster` and `minEnergy`.
  - Set `rdIndex`=0, `found`=0, and clear the best registers.
- SCAN:
  - `rdIndex` increments every cycle until it reaches N-1, then holds.
  - A one-bit pending flag tracks that the read data corresponds to index `rdIndex`-1.
  - Each returned entry is compared once.
- Eligibility:
  - Requires `mEnergyLeft` ≥ `minEnergy`, unsigned.
  - When `filterCluster`=1, also requires (`mClusterID`==`myClusterID` OR `mSourceID`==`myClusterID`).
- Replacement: an eligible entry replaces the current best if `found`=0, or Q > bestQ, or (Q == bestQ and energy > bestEnergy). All comparisons are unsigned 16-bit.
- Ties on both Q and energy keep the lower index (the first one seen).
- `en` is ignored while `busy`=1 or in DONE.
- Results are held until the next accepted `en`.
- If no entry passes the filters: `found`=0 and every best output is 0.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset mid-scan aborts immediately and loses the partial results.
- Latency: with `en` sampled at edge E0, entry k is compared at edge E(k+2). `done` is high during the cycle after edge E(N+1), so it is asserted N+1 cycles after the start edge.
- N=0: `done` follows one cycle after start, with `found`=0.
- `busy`: high from E0 until the edge at which `done` rises.
- Best outputs are stable and valid whenever `done`=1 and afterwards.
- `rdIndex` returns to 0 in IDLE so the Q-table update stage can own the banks. The index mux between the two stages belongs to the top level.
- The block never writes the banks.

## Structure
- Shared package `eerrl_pkg` holds `WORD_WIDTH`, `MEM_DEPTH`, the packet-type constants, and the state enum for this block.
- One natural sub-module, `hop_better_cmp`, is purely combinational. Inputs: candidate Q/energy, best Q/energy, `found`. Output: replace.
- The top module holds the FSM, index counter, pending flag, and best registers.

## Test plan
- Empty table: `neighborCount`=0, `en` pulse → `done` one cycle later, `found`=0, all best outputs 0.
- Basic max: 4 entries with Q = 0x1000, 0x3000, 0x2000, 0x3000 and energies 0x8000, 0x4000, 0x8000, 0x4000 → index 1 wins (first of the equal pair), `done` 5 cycles after start.
- Energy tie-break: Q equal at 0x3000, energies 0x1800 and 0x8000 → the entry with energy 0x8000 is chosen.
- Filters:
  - `minEnergy`=0x2000 with the highest-Q entry at energy 0x1000 → that entry is skipped.
  - `filterCluster`=1, `myClusterID`=2 → only cluster-2 members or ID 2 are eligible.
  - A case where every entry fails → `found`=0.
- Robustness:
  - `en` re-pulsed mid-scan → ignored, results unchanged.
  - `nrst` asserted mid-scan → outputs return to 0 at once; a fresh scan then completes correctly.
- Clamp: `neighborCount`=3000 → scan stops at index 2047, and `done` comes 2049 cycles after start.
